// File: rtl/csa_accum_seq_if.sv
// Operand-in / result-out bus for the carry-save packet accumulator.
// The master drives operand beats and accepts results; the slave (the
// accumulator) flow-controls beats with in_ready and presents results.
interface csa_accum_seq_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/csa_accum_seq.sv
// Packet accumulator built around a 5:2 carry-save compressor.
// Operands are collected three at a time, then folded together with the
// redundant (sum, carry) accumulator in one compressor pass. Only after the
// last operand of a packet is the redundant pair resolved by a single
// carry-propagate add, giving the packet sum modulo 2^WIDTH plus a
// saturating operand count.

// 5:2 compressor: s1 + s2 == a1+a2+a3+a4+a5 (mod 2^WIDTH).
// Built as a chain of three 3:2 carry-save stages; no carry propagation.
module compressor5_2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] a2_i,
  input  logic [WIDTH-1:0] a3_i,
  input  logic [WIDTH-1:0] a4_i,
  input  logic [WIDTH-1:0] a5_i,
  output logic [WIDTH-1:0] s1_o,
  output logic [WIDTH-1:0] s2_o
);
  // One 3:2 stage; returns {carry (already shifted left by one), sum}.
  // The carry bit leaving the top position is dropped, which is exactly
  // the modulo-2^WIDTH behaviour wanted.
  function automatic logic [2*WIDTH-1:0] csa3(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic [WIDTH-1:0] z
  );
    logic [WIDTH-1:0] sum_v;
    logic [WIDTH-1:0] maj_v;
    sum_v = x ^ y ^ z;
    maj_v = (x & y) | (x & z) | (y & z);
    return {maj_v[WIDTH-2:0], 1'b0, sum_v};
  endfunction

  logic [WIDTH-1:0] st1_s;
  logic [WIDTH-1:0] st1_c;
  logic [WIDTH-1:0] st2_s;
  logic [WIDTH-1:0] st2_c;

  assign {st1_c, st1_s} = csa3(a1_i, a2_i, a3_i);
  assign {st2_c, st2_s} = csa3(st1_s, st1_c, a4_i);
  assign {s2_o, s1_o}   = csa3(st2_s, st2_c, a5_i);
endmodule

module csa_accum_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  csa_accum_seq_if.slave      bus
);
  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_COMPRESS = 2'd1,
    ST_FINAL    = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] OPS_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] OPS_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};

  // State registers and their next-state values
  state_t           state_q,     state_d;
  logic [WIDTH-1:0] buf0_q,      buf0_d;
  logic [WIDTH-1:0] buf1_q,      buf1_d;
  logic [WIDTH-1:0] buf2_q,      buf2_d;
  logic [1:0]       cnt_q,       cnt_d;
  logic [WIDTH-1:0] acc_s_q,     acc_s_d;
  logic [WIDTH-1:0] acc_c_q,     acc_c_d;
  logic             last_seen_q, last_seen_d;
  logic [CNT_W-1:0] ops_q,       ops_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  // Compressor operands and results
  logic [WIDTH-1:0] comp_a1;
  logic [WIDTH-1:0] comp_a2;
  logic [WIDTH-1:0] comp_a3;
  logic [WIDTH-1:0] comp_s1;
  logic [WIDTH-1:0] comp_s2;
  logic             beat_acc;

  // Buffer slots not filled in this group contribute zero to the fold.
  always_comb begin
    comp_a1 = (cnt_q > 2'd0) ? buf0_q : ZERO_W;
    comp_a2 = (cnt_q > 2'd1) ? buf1_q : ZERO_W;
    comp_a3 = (cnt_q > 2'd2) ? buf2_q : ZERO_W;
  end

  compressor5_2 #(
    .WIDTH (WIDTH)
  ) u_comp (
    .a1_i (comp_a1),
    .a2_i (comp_a2),
    .a3_i (comp_a3),
    .a4_i (acc_s_q),
    .a5_i (acc_c_q),
    .s1_o (comp_s1),
    .s2_o (comp_s2)
  );

  // in_ready_q is only ever high in COLLECT, so this is the beat handshake.
  assign beat_acc = bus.in_valid && in_ready_q;

  // Next-state logic for the whole controller and datapath.
  always_comb begin
    state_d     = state_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    buf2_d      = buf2_q;
    cnt_d       = cnt_q;
    acc_s_d     = acc_s_q;
    acc_c_d     = acc_c_q;
    last_seen_d = last_seen_q;
    ops_d       = ops_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;

    case (state_q)
      ST_COLLECT: begin
        // in_ready is registered so that it is low through reset and
        // rises on the first edge after reset is released.
        if (beat_acc) begin
          case (cnt_q)
            2'd0:    buf0_d = bus.in_data;
            2'd1:    buf1_d = bus.in_data;
            2'd2:    buf2_d = bus.in_data;
            default: buf0_d = buf0_q;
          endcase
          cnt_d       = cnt_q + 2'd1;
          ops_d       = (ops_q == OPS_MAX) ? ops_q : (ops_q + OPS_ONE);
          last_seen_d = bus.in_last;
          if ((cnt_q == 2'd2) || bus.in_last) begin
            state_d    = ST_COMPRESS;
            in_ready_d = 1'b0;
          end else begin
            state_d    = ST_COLLECT;
            in_ready_d = 1'b1;
          end
        end else begin
          in_ready_d = 1'b1;
        end
      end

      ST_COMPRESS: begin
        acc_s_d = comp_s1;
        acc_c_d = comp_s2;
        cnt_d   = 2'd0;
        buf0_d  = ZERO_W;
        buf1_d  = ZERO_W;
        buf2_d  = ZERO_W;
        if (last_seen_q) begin
          state_d    = ST_FINAL;
          in_ready_d = 1'b0;
        end else begin
          state_d    = ST_COLLECT;
          in_ready_d = 1'b1;
        end
      end

      ST_FINAL: begin
        // The single carry-propagate add of the packet; carry-out dropped.
        out_data_d  = acc_s_q + acc_c_q;
        out_count_d = ops_q;
        out_valid_d = 1'b1;
        in_ready_d  = 1'b0;
        state_d     = ST_DONE;
      end

      ST_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          acc_s_d     = ZERO_W;
          acc_c_d     = ZERO_W;
          ops_d       = {CNT_W{1'b0}};
          last_seen_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_COLLECT;
        end else begin
          in_ready_d  = 1'b0;
          state_d     = ST_DONE;
        end
      end

      default: begin
        state_d    = ST_COLLECT;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // Controller and datapath registers; async reset discards all packet state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      buf0_q      <= ZERO_W;
      buf1_q      <= ZERO_W;
      buf2_q      <= ZERO_W;
      cnt_q       <= 2'd0;
      acc_s_q     <= ZERO_W;
      acc_c_q     <= ZERO_W;
      last_seen_q <= 1'b0;
      ops_q       <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= ZERO_W;
      out_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      buf2_q      <= buf2_d;
      cnt_q       <= cnt_d;
      acc_s_q     <= acc_s_d;
      acc_c_q     <= acc_c_d;
      last_seen_q <= last_seen_d;
      ops_q       <= ops_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_csa_accum_seq.sv
// Scoreboard bench for csa_accum_seq: the stimulus process keeps a plain
// arithmetic packet model and queues expected results; a monitor process
// drives out_ready and checks every presented result against the queue.
module tb_csa_accum_seq;
  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  csa_accum_seq_if #(.WIDTH(32), .CNT_W(8)) bus ();

  csa_accum_seq #(.WIDTH(32), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cnt;
    int          t_acc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: packet sum and saturating count
  longint unsigned m_sum;
  int              m_ops;

  // Monitor controls
  int hold_n;
  int hold_cnt;
  bit rand_rdy;
  bit prev_ov;
  bit after_hs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: drives out_ready and checks results against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.out_ready = 1'b0;
      prev_ov  = 1'b0;
      hold_cnt = 0;
      after_hs = 1'b0;
    end else begin
      if (after_hs) begin
        chk("in_ready_after_handshake", {63'd0, bus.in_ready}, 64'd1);
        after_hs = 1'b0;
      end
      if (bus.out_valid && !prev_ov) begin
        chk("result_expected", {63'd0, exp_q.size() > 0}, 64'd1);
        if (exp_q.size() > 0)
          chk("latency", cyc, exp_q[0].t_acc + 2);
        hold_cnt = hold_n;
      end
      if (bus.out_valid) begin
        chk("in_ready_low_while_done", {63'd0, bus.in_ready}, 64'd0);
        if (exp_q.size() > 0) begin
          chk("out_data", {32'd0, bus.out_data}, {32'd0, exp_q[0].data});
          chk("out_count", {56'd0, bus.out_count}, exp_q[0].cnt);
        end
      end
      if (hold_cnt > 0) begin
        bus.out_ready = 1'b0;
        hold_cnt--;
      end else if (rand_rdy) begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.out_ready = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        after_hs = 1'b1;
      end
      prev_ov = bus.out_valid;
    end
  end

  // Offer one beat (called at a negedge); returns at a negedge after acceptance.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      chk("beat_accept_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
    end else begin
      m_sum = (m_sum + longint'(d)) & 64'hFFFF_FFFF;
      m_ops = (m_ops < 255) ? m_ops + 1 : 255;
      if (l) begin
        exp_q.push_back('{data: m_sum[31:0], cnt: m_ops, t_acc: cyc + 1});
        m_sum = 64'd0;
        m_ops = 0;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
      bus.in_last  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_timeout", {63'd0, g < 3000}, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  {63'd0, bus.in_ready},  64'd0);
    chk({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
    chk({tag, "_out_data"},  {32'd0, bus.out_data},  64'd0);
    chk({tag, "_out_count"}, {56'd0, bus.out_count}, 64'd0);
  endtask

  // Release reset at a negedge; in_ready must rise only at the next edge.
  task automatic release_reset();
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_first_edge", {63'd0, bus.in_ready}, 64'd0);
    @(negedge clk);
    chk("in_ready_after_first_edge", {63'd0, bus.in_ready}, 64'd1);
  endtask

  initial begin
    int len;
    logic [31:0] d;
    checks = 0; failures = 0; cyc = 0;
    m_sum = 64'd0; m_ops = 0;
    hold_n = 0; rand_rdy = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 32'd0; bus.in_last = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    release_reset();

    // 1..5, last on 5
    for (int i = 1; i <= 5; i++) send_beat(32'(i), i == 5);
    wait_idle();
    // single operand packet
    send_beat(32'hDEAD_BEEF, 1'b1);
    wait_idle();
    // wrap-around
    send_beat(32'hFFFF_FFFF, 1'b0);
    send_beat(32'hFFFF_FFFF, 1'b0);
    send_beat(32'd2, 1'b1);
    wait_idle();
    // consumer back-pressure for 10 cycles, then an immediate next packet
    hold_n = 10;
    send_beat(32'd7, 1'b0);
    send_beat(32'd8, 1'b1);
    send_beat(32'd4, 1'b1);
    hold_n = 0;
    wait_idle();

    // reset mid-packet discards the partial sum
    send_beat(32'd10, 1'b0);
    send_beat(32'd20, 1'b0);
    #2 rst_n = 1'b0;
    m_sum = 64'd0; m_ops = 0;
    #1 check_reset_outputs("midpkt_reset");
    @(negedge clk);
    release_reset();
    send_beat(32'd3, 1'b1);
    wait_idle();

    // reset while a result is pending discards it
    hold_n = 40;
    send_beat(32'd5, 1'b0);
    send_beat(32'd6, 1'b1);
    repeat (6) @(negedge clk);
    chk("pending_before_reset", {63'd0, bus.out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    hold_n = 0;
    #1 check_reset_outputs("done_reset");
    @(negedge clk);
    release_reset();
    send_beat(32'd9, 1'b1);
    wait_idle();

    // count saturation: 300 ones
    for (int i = 1; i <= 300; i++) send_beat(32'd1, i == 300);
    wait_idle();

    // random packets with random consumer readiness
    rand_rdy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
        send_beat(d, i == len - 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    wait_idle();
    chk("scoreboard_empty", exp_q.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/csa_accum_seq.md
CSA_ACCUM_SEQ -- requirements
Module: csa_accum_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, operand-count output width.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1, operand beat valid.
REQ-006 Port in_data, input, WIDTH, operand value (unsigned).
REQ-007 Port in_last, input, 1, marks the final operand of a packet.
REQ-008 Port in_ready, output, 1, block accepts a beat this cycle.
REQ-009 Port out_valid, output, 1, result valid.
REQ-010 Port out_data, output, WIDTH, packet sum modulo 2^WIDTH.
REQ-011 Port out_count, output, CNT_W, operands in the packet, saturating at 2^CNT_W-1.
REQ-012 Port out_ready, input, 1, consumer accepts the result.

Function
REQ-013 The block SHALL instantiate one compressor5_2 (WIDTH=32 datapath) and rely only on S1+S2 == A1+A2+A3+A4+A5 mod 2^WIDTH.
REQ-014 Registers: buf0..buf2 (WIDTH), cnt (0..3), acc_s, acc_c (WIDTH), last_seen, ops (CNT_W), state.
REQ-015 States SHALL be COLLECT, COMPRESS, FINAL, DONE.
REQ-016 COLLECT: in_ready=1; on in_valid, buf[cnt]<=in_data, cnt++, ops++ (saturating), last_seen<=in_last.
REQ-017 COLLECT -> COMPRESS when the accepted beat makes cnt==3 or has in_last=1; otherwise stay.
REQ-018 COMPRESS (1 cycle, in_ready=0): compressor inputs A1..A3=buf0..buf2 with unfilled slots forced to 0, A4=acc_s, A5=acc_c; acc_s<=S1, acc_c<=S2; cnt<=0; buffers cleared.
REQ-019 COMPRESS -> FINAL if last_seen, else -> COLLECT.
REQ-020 FINAL (1 cycle, in_ready=0): out_data<=acc_s+acc_c (carry out discarded), out_count<=ops, out_valid<=1; -> DONE.
REQ-021 DONE: in_ready=0; out_valid, out_data, out_count held stable until out_valid&&out_ready.
REQ-022 On handshake in DONE: out_valid<=0, acc_s, acc_c, ops, last_seen <=0; -> COLLECT (next beat accepted the following cycle).
REQ-023 Latency: beat with in_last accepted at edge T -> out_valid high after edge T+2 (COMPRESS, FINAL); out_ready held high -> one result every (ceil(N/3)*4... per group: 3 beats + 1 compress) cycles plus 2.
REQ-024 in_ready SHALL be 1 only in COLLECT; a beat offered while in_ready=0 is not consumed and SHALL not alter state.
REQ-025 A 1-operand packet (first beat has in_last=1) SHALL produce out_data=that operand, out_count=1.
REQ-026 Sum overflow wraps modulo 2^WIDTH; no overflow flag.
REQ-027 ops saturates at 2^CNT_W-1; further beats still add into the sum.
REQ-028 in_data/in_last are sampled only when in_valid&&in_ready.

Reset
REQ-029 rst_n low SHALL asynchronously force state=COLLECT, all registers 0, in_ready=0 while rst_n low, out_valid=0, out_data=0, out_count=0.
REQ-030 Reset mid-packet or in DONE SHALL discard partial sums and pending result; first beat after release starts a new packet.
REQ-031 in_ready SHALL rise at the first clk edge after rst_n deasserts.

Verification
REQ-032 Beats 1,2,3,4,5 (last on 5), out_ready=1 -> out_data=15, out_count=5, out_valid one cycle after FINAL.
REQ-033 Single beat 0xDEADBEEF with in_last -> out_data=0xDEADBEEF, out_count=1, out_valid 2 cycles after acceptance.
REQ-034 Beats 0xFFFFFFFF,0xFFFFFFFF,2 (last) -> out_data=0x00000000, out_count=3 (wrap).
REQ-035 Packet 7,8 (last) with out_ready=0 for 10 cycles -> out_valid/out_data=15 held, in_ready=0 throughout; next packet accepted the cycle after out_ready rises.
REQ-036 rst_n pulsed low after beats 10,20 (no last), then packet 3 (last) -> out_data=3, out_count=1.
REQ-037 300 beats of value 1 (last on 300) -> out_data=300, out_count=255 (saturated).
